// File: rtl/subtractor_pkg.sv
// rtl/subtractor_pkg.sv - shared build defaults for the subtractor pipeline
//
// Purpose: default operand and counter widths used by the subtractor top
//          and its pipeline stage.
// Ports:   none (package).
// Config:  the SUB_SAT_EN macro is consumed in rtl/subtractor.sv.

package subtractor_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/subtractor_pipe_stage.sv
// rtl/subtractor_pipe_stage.sv - one valid/ready register slice with load/hold
//
// Purpose: holds one item. It loads when empty or when its content leaves
//          in the same cycle, so a chain of slices runs without bubbles.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   up_valid   upstream item present
//   up_ready   slice can take an item this cycle (combinational from dn_ready)
//   up_data    upstream payload
//   dn_valid   slice holds an item
//   dn_ready   downstream takes the held item this cycle
//   dn_data    held payload, stable while dn_valid & ~dn_ready

module subtractor_pipe_stage
  import subtractor_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  // Ready chains combinationally so a full pipe can advance every cycle.
  assign up_ready = ~dn_valid | dn_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      // Only capture real data so the held payload does not toggle on idles.
      if (up_valid) begin
        dn_data <= up_data;
      end
    end
  end

endmodule

// File: rtl/subtractor.sv
// rtl/subtractor.sv - two-stage registered subtractor recovering an adder operand
//
// Purpose: diff = sum - operand, where sum is a (DATA_W+1)-bit adder result.
//          S1 registers the operands, S2 registers the reduced difference.
//          Out-of-range results raise err_o; saturating transfer/error counters.
// Config:  SUB_SAT_EN defined   -> out-of-range diff_o clamps to 0 / all-ones.
//          SUB_SAT_EN undefined -> diff_o is the low DATA_W bits (wraps).
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   in_valid_i     sum_i/data_i valid
//   in_ready_o     input transfer when in_valid_i & in_ready_o
//   sum_i          minuend, DATA_W+1 bits
//   data_i         subtrahend, DATA_W bits
//   out_valid_o    diff_o/err_o valid
//   out_ready_i    output transfer when out_valid_o & out_ready_i
//   diff_o         recovered operand
//   err_o          true difference outside [0, 2^DATA_W-1]
//   txn_cnt_o      saturating count of output transfers
//   err_cnt_o      saturating count of output transfers with err_o=1

module subtractor
  import subtractor_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W:0]   sum_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] diff_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  txn_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam int S1_W = 2 * DATA_W + 1;
  localparam int S2_W = DATA_W + 1;

  logic                     s1_valid;
  logic                     s2_ready;
  logic [S1_W-1:0]          s1_q;
  logic [DATA_W:0]          s1_sum;
  logic [DATA_W-1:0]        s1_data;
  logic signed [DATA_W+1:0] d;
  logic                     err_next;
  logic [DATA_W-1:0]        diff_next;
  logic [S2_W-1:0]          s2_q;
  logic                     out_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + CNT_W'(1);
  endfunction

  subtractor_pipe_stage #(.W(S1_W)) u_s1 (
    .clk      (clk_i),
    .rst      (rst_i),
    .up_valid (in_valid_i),
    .up_ready (in_ready_o),
    .up_data  ({sum_i, data_i}),
    .dn_valid (s1_valid),
    .dn_ready (s2_ready),
    .dn_data  (s1_q)
  );

  assign {s1_sum, s1_data} = s1_q;

  // Two extra bits: the sign, plus the carry-out bit that the sum already has.
  assign d        = {1'b0, s1_sum} - {2'b00, s1_data};
  assign err_next = d[DATA_W+1] | d[DATA_W];

  always_comb begin
    diff_next = d[DATA_W-1:0];
`ifdef SUB_SAT_EN
    if (d[DATA_W+1]) begin
      diff_next = '0;
    end else if (d[DATA_W]) begin
      diff_next = '1;
    end
`endif
  end

  subtractor_pipe_stage #(.W(S2_W)) u_s2 (
    .clk      (clk_i),
    .rst      (rst_i),
    .up_valid (s1_valid),
    .up_ready (s2_ready),
    .up_data  ({err_next, diff_next}),
    .dn_valid (out_valid_o),
    .dn_ready (out_ready_i),
    .dn_data  (s2_q)
  );

  assign {err_o, diff_o} = s2_q;

  assign out_fire = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      txn_cnt_o <= '0;
      err_cnt_o <= '0;
    end else if (out_fire) begin
      txn_cnt_o <= sat_inc(txn_cnt_o);
      if (err_o) begin
        err_cnt_o <= sat_inc(err_cnt_o);
      end
    end
  end

endmodule

// File: tb/tb_subtractor.sv
// tb/tb_subtractor.sv - self-checking bench for the subtractor pipeline

module tb_subtractor;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW:0]   sum;
  logic [DW-1:0] data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] diff;
  logic          err;
  logic [15:0]   txn_cnt;
  logic [15:0]   err_cnt;

  logic          in_ready_s;
  logic          out_valid_s;
  logic [DW-1:0] diff_s;
  logic          err_s;
  logic [3:0]    txn_cnt_s;
  logic [3:0]    err_cnt_s;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DW-1:0] diff;
    logic          err;
  } res_t;

  typedef struct {
    logic [DW:0]   sum;
    logic [DW-1:0] data;
    logic [DW-1:0] diff_wrap;
    logic [DW-1:0] diff_sat;
    logic          err;
  } vec_t;

  res_t exp_q[$];
  int   txn_m = 0;
  int   err_m = 0;

  always #5 clk = ~clk;

  subtractor dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .sum_i       (sum),
    .data_i      (data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .diff_o      (diff),
    .err_o       (err),
    .txn_cnt_o   (txn_cnt),
    .err_cnt_o   (err_cnt)
  );

  subtractor #(.CNT_W(4)) dut_s (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_s),
    .sum_i       (sum),
    .data_i      (data),
    .out_valid_o (out_valid_s),
    .out_ready_i (out_ready),
    .diff_o      (diff_s),
    .err_o       (err_s),
    .txn_cnt_o   (txn_cnt_s),
    .err_cnt_o   (err_cnt_s)
  );

  // Reference: plain integer arithmetic on the true difference.
  function automatic res_t model(input logic [DW:0] s, input logic [DW-1:0] o);
    res_t r;
    int   v;
    v     = int'(s) - int'(o);
    r.err = (v < 0) || (v > 65535);
`ifdef SUB_SAT_EN
    if (v < 0)          r.diff = '0;
    else if (v > 65535) r.diff = '1;
    else                r.diff = v[15:0];
`else
    r.diff = v[15:0];
`endif
    return r;
  endfunction

  function automatic int sat(input int v, input int max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock: sample at the falling edge, score transfers, then step past the rising edge.
  task automatic cycle();
    bit   in_fire;
    bit   out_fire;
    res_t r;
    @(negedge clk);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    check("txn_cnt", 32'(txn_cnt), 32'(sat(txn_m, 65535)));
    check("err_cnt", 32'(err_cnt), 32'(sat(err_m, 65535)));
    check("txn_cnt_small", 32'(txn_cnt_s), 32'(sat(txn_m, 15)));
    check("err_cnt_small", 32'(err_cnt_s), 32'(sat(err_m, 15)));
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output actual=%0h required=none", diff);
      end else begin
        r = exp_q.pop_front();
        check("diff", 32'(diff), 32'(r.diff));
        check("err", 32'(err), 32'(r.err));
        check("diff_small", 32'(diff_s), 32'(r.diff));
        txn_m++;
        if (r.err) err_m++;
      end
    end
    if (in_fire) exp_q.push_back(model(sum, data));
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    exp_q.delete();
    txn_m = 0;
    err_m = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) cycle();
    cycle();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Single op on an idle pipe: checks latency and the table values.
  task automatic single_op(input vec_t v, input string tag);
    logic [DW-1:0] want;
`ifdef SUB_SAT_EN
    want = v.diff_sat;
`else
    want = v.diff_wrap;
`endif
    in_valid  = 1'b1;
    sum       = v.sum;
    data      = v.data;
    out_ready = 1'b1;
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    cycle();
    in_valid = 1'b0;
    sum      = 17'($urandom);
    data     = 16'($urandom);
    check({tag, "_valid_after_1"}, 32'(out_valid), 32'd0);
    cycle();
    check({tag, "_valid_after_2"}, 32'(out_valid), 32'd1);
    check({tag, "_diff"}, 32'(diff), 32'(want));
    check({tag, "_err"}, 32'(err), 32'(v.err));
    cycle();
    check({tag, "_valid_after_xfer"}, 32'(out_valid), 32'd0);
  endtask

  vec_t          vecs[10];
  int            accepts;
  bit            held;
  logic [DW-1:0] hold_diff;
  logic          hold_err;

  initial begin
    vecs[0] = '{17'h1_0005, 16'h0006, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[1] = '{17'h0_0003, 16'h0005, 16'hFFFE, 16'h0000, 1'b1};
    vecs[2] = '{17'h1_FFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[3] = '{17'h0_0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[4] = '{17'h1_0000, 16'h0000, 16'h0000, 16'hFFFF, 1'b1};
    vecs[5] = '{17'h0_FFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0};
    vecs[6] = '{17'h1_0000, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[7] = '{17'h0_0000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[8] = '{17'h1_FFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1};
    vecs[9] = '{17'h1_2345, 16'h1111, 16'h1234, 16'hFFFF, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum       = '0;
    data      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_txn_cnt", 32'(txn_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;

    // Table vectors, one at a time.
    for (int i = 0; i < 10; i++) begin
      single_op(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) check("vec0_txn_cnt", 32'(txn_cnt), 32'd1);
      if (i == 1) check("vec1_err_cnt", 32'(err_cnt), 32'd1);
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      sum       = 17'($urandom);
      data      = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    // Continuous stream: no bubbles, simultaneous in/out transfers.
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      sum      = 17'($urandom);
      data     = 16'($urandom);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      if (i >= 2) check("stream_no_bubble", 32'(out_valid), 32'd1);
      cycle();
    end
    in_valid = 1'b0;
    check("stream_tail_valid", 32'(out_valid), 32'd1);
    cycle();
    check("stream_tail_valid2", 32'(out_valid), 32'd1);
    cycle();
    cycle();
    check("stream_txn_cnt", 32'(txn_cnt), 32'd8);

    // Backpressure: two accepts fill the pipe, output holds steady.
    out_ready = 1'b0;
    accepts   = 0;
    held      = 1'b0;
    hold_diff = '0;
    hold_err  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      sum      = 17'($urandom);
      data     = 16'($urandom);
      if (accepts >= 2) check("bp_in_ready", 32'(in_ready), 32'd0);
      if (held) begin
        check("bp_valid_hold", 32'(out_valid), 32'd1);
        check("bp_diff_hold", 32'(diff), 32'(hold_diff));
        check("bp_err_hold", 32'(err), 32'(hold_err));
      end else if (out_valid) begin
        held      = 1'b1;
        hold_diff = diff;
        hold_err  = err;
      end
      if (in_ready) accepts++;
      cycle();
    end
    check("bp_accepts", 32'(accepts), 32'd2);
    drain();
    check("bp_txn_cnt", 32'(txn_cnt), 32'd10);

    // Reset with two items in flight acts without a clock edge.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      sum      = 17'($urandom);
      data     = 16'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    check("pre_rst_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #2;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_txn_cnt", 32'(txn_cnt), 32'd0);
    check("async_rst_err_cnt", 32'(err_cnt), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    exp_q.delete();
    txn_m = 0;
    err_m = 0;
    @(posedge clk);
    #1;
    single_op(vecs[0], "post_rst");
    check("post_rst_txn_cnt", 32'(txn_cnt), 32'd1);

    // Counter saturation on the 4-bit instance: 20 more error results.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      sum      = {1'b1, 16'($urandom)};
      data     = 16'h0000;
      cycle();
    end
    drain();
    check("sat_txn_small", 32'(txn_cnt_s), 32'hF);
    check("sat_err_small", 32'(err_cnt_s), 32'hF);
    check("sat_txn_wide", 32'(txn_cnt), 32'd21);
    check("sat_err_wide", 32'(err_cnt), 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
